// File: rtl/bla_subtractor_seq.sv
// Sequential unsigned subtractor: a - b, one 4-bit borrow-lookahead nibble per
// clock (LSB first), with a registered borrow chained between nibbles.
module bla_subtractor_seq #(
    parameter int unsigned WIDTH = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] diff,
    output logic             borrow,
    output logic             zero
);

    localparam int unsigned NIB = WIDTH / 4;
    localparam int unsigned CW  = (NIB > 1) ? $clog2(NIB) : 1;
    localparam logic [CW-1:0] LAST = CW'(NIB - 1);

    typedef enum logic [1:0] {
        S_IDLE,
        S_CALC,
        S_DONE
    } state_t;

    state_t           r_state;
    state_t           w_state_nxt;

    logic [WIDTH-1:0] r_a;
    logic [WIDTH-1:0] r_b;
    logic [WIDTH-1:0] r_diff;
    logic [CW-1:0]    r_cnt;
    logic             r_run_bw;
    logic             r_borrow;
    logic             r_zero;

    logic             w_accept;
    logic             w_release;
    logic             w_last;
    logic [CW+1:0]    w_base;
    logic [3:0]       w_an;
    logic [3:0]       w_bn;
    logic [3:0]       w_g;
    logic [3:0]       w_p;
    logic [4:0]       w_bw;
    logic [3:0]       w_d;
    logic [WIDTH-1:0] w_diff_nxt;

    assign in_ready  = (r_state == S_IDLE);
    assign out_valid = (r_state == S_DONE);
    assign diff      = r_diff;
    assign borrow    = r_borrow;
    assign zero      = r_zero;

    assign w_accept  = in_valid && (r_state == S_IDLE);
    assign w_release = out_ready && (r_state == S_DONE);
    assign w_last    = (r_cnt == LAST);

    // Current nibble of the captured operands
    assign w_base = {r_cnt, 2'b00};
    assign w_an   = r_a[w_base +: 4];
    assign w_bn   = r_b[w_base +: 4];

    assign w_g = ~w_an & w_bn;
    assign w_p = ~(w_an ^ w_bn);

    // Flattened lookahead: every borrow depends only on g/p and the nibble borrow-in
    assign w_bw[0] = r_run_bw;
    assign w_bw[1] = w_g[0]
                   | (w_p[0] & r_run_bw);
    assign w_bw[2] = w_g[1]
                   | (w_p[1] & w_g[0])
                   | (w_p[1] & w_p[0] & r_run_bw);
    assign w_bw[3] = w_g[2]
                   | (w_p[2] & w_g[1])
                   | (w_p[2] & w_p[1] & w_g[0])
                   | (w_p[2] & w_p[1] & w_p[0] & r_run_bw);
    assign w_bw[4] = w_g[3]
                   | (w_p[3] & w_g[2])
                   | (w_p[3] & w_p[2] & w_g[1])
                   | (w_p[3] & w_p[2] & w_p[1] & w_g[0])
                   | (w_p[3] & w_p[2] & w_p[1] & w_p[0] & r_run_bw);

    assign w_d = w_an ^ w_bn ^ w_bw[3:0];

    always_comb begin
        w_diff_nxt               = r_diff;
        w_diff_nxt[w_base +: 4]  = w_d;
    end

    always_comb begin
        w_state_nxt = r_state;
        unique case (r_state)
            S_IDLE: if (w_accept)  w_state_nxt = S_CALC;
            S_CALC: if (w_last)    w_state_nxt = S_DONE;
            S_DONE: if (w_release) w_state_nxt = S_IDLE;
            default:               w_state_nxt = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_a      <= '0;
            r_b      <= '0;
            r_diff   <= '0;
            r_cnt    <= '0;
            r_run_bw <= 1'b0;
            r_borrow <= 1'b0;
            r_zero   <= 1'b0;
        end else begin
            unique case (r_state)
                S_IDLE: begin
                    if (w_accept) begin
                        r_a      <= a;
                        r_b      <= b;
                        r_cnt    <= '0;
                        r_run_bw <= 1'b0;
                    end
                end
                S_CALC: begin
                    r_diff   <= w_diff_nxt;
                    r_run_bw <= w_bw[4];
                    if (w_last) begin
                        r_borrow <= w_bw[4];
                        r_zero   <= (w_diff_nxt == '0);
                    end else begin
                        r_cnt    <= r_cnt + 1'b1;
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_bla_subtractor_seq.sv
// Scoreboard bench for bla_subtractor_seq: WIDTH=16 directed cases and a
// WIDTH=4 random back-to-back run against a behavioural subtract model.
module tb_bla_subtractor_seq;

    typedef struct {
        logic [15:0] d;
        logic        bo;
        logic        z;
        int unsigned acc;
    } exp_t;

    logic clk;
    logic rst_n;
    int unsigned cyc;
    int unsigned n_checks;
    int unsigned n_errors;

    exp_t q16[$];
    exp_t q4[$];

    logic        iv16, ir16, ov16, or16, bo16, z16;
    logic [15:0] a16, b16, d16;
    logic        iv4, ir4, ov4, or4, bo4, z4;
    logic [3:0]  a4, b4, d4;

    logic        prev16, prev4;
    int unsigned start16, start4;
    logic        b2b;
    logic        have_last4;
    int unsigned last_pop4;

    bla_subtractor_seq #(.WIDTH(16)) u16 (
        .clk(clk), .rst_n(rst_n),
        .in_valid(iv16), .in_ready(ir16), .a(a16), .b(b16),
        .out_valid(ov16), .out_ready(or16),
        .diff(d16), .borrow(bo16), .zero(z16)
    );

    bla_subtractor_seq #(.WIDTH(4)) u4 (
        .clk(clk), .rst_n(rst_n),
        .in_valid(iv4), .in_ready(ir4), .a(a4), .b(b4),
        .out_valid(ov4), .out_ready(or4),
        .diff(d4), .borrow(bo4), .zero(z4)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic exp_t model16(input logic [15:0] a, input logic [15:0] b, input int unsigned acc);
        exp_t e;
        e.d   = a - b;
        e.bo  = (a < b);
        e.z   = (a == b);
        e.acc = acc;
        return e;
    endfunction

    function automatic exp_t model4(input logic [3:0] a, input logic [3:0] b, input int unsigned acc);
        exp_t e;
        logic [3:0] t;
        t     = a - b;
        e.d   = {12'h000, t};
        e.bo  = (a < b);
        e.z   = (a == b);
        e.acc = acc;
        return e;
    endfunction

    // Output side of the scoreboards: compare when a result is handed over
    always @(negedge clk) begin
        exp_t e;
        if (!rst_n) begin
            prev16 = 1'b0;
        end else begin
            if (ov16 && !prev16) start16 = cyc;
            prev16 = ov16;
            if (ov16 && or16) begin
                check("sb16_nonempty", 32'(q16.size() != 0), 32'd1);
                if (q16.size() != 0) begin
                    e = q16.pop_front();
                    check("diff16",    32'(d16),  32'(e.d));
                    check("borrow16",  32'(bo16), 32'(e.bo));
                    check("zero16",    32'(z16),  32'(e.z));
                    check("latency16", start16 - e.acc - 1, 32'd4);
                end
            end
        end
    end

    always @(negedge clk) begin
        exp_t e;
        if (!rst_n) begin
            prev4      = 1'b0;
            have_last4 = 1'b0;
        end else begin
            if (ov4 && !prev4) start4 = cyc;
            prev4 = ov4;
            if (ov4 && or4) begin
                check("sb4_nonempty", 32'(q4.size() != 0), 32'd1);
                if (q4.size() != 0) begin
                    e = q4.pop_front();
                    check("diff4",    32'(d4),  32'(e.d[3:0]));
                    check("borrow4",  32'(bo4), 32'(e.bo));
                    check("zero4",    32'(z4),  32'(e.z));
                    check("latency4", start4 - e.acc - 1, 32'd1);
                end
                if (b2b && have_last4) check("interval4", cyc - last_pop4, 32'd3);
                last_pop4  = cyc;
                have_last4 = b2b;
            end
        end
    end

    task automatic send16(input logic [15:0] a, input logic [15:0] b);
        logic done;
        done = 1'b0;
        iv16 = 1'b1;
        a16  = a;
        b16  = b;
        for (int k = 0; k < 50 && !done; k++) begin
            @(negedge clk);
            if (ir16) begin
                q16.push_back(model16(a, b, cyc));
                done = 1'b1;
            end
        end
        if (!done) check("send16_timeout", 32'd0, 32'd1);
        @(posedge clk);
        #1;
        iv16 = 1'b0;
    endtask

    task automatic drain16();
        for (int k = 0; k < 100 && q16.size() != 0; k++) @(posedge clk);
        #1;
        check("drain16", 32'(q16.size()), 32'd0);
    endtask

    task automatic wait_ov16();
        for (int k = 0; k < 50 && !ov16; k++) @(negedge clk);
        check("wait_ov16", 32'(ov16), 32'd1);
    endtask

    initial begin
        n_checks = 0;
        n_errors = 0;
        b2b = 1'b0;
        have_last4 = 1'b0;
        prev16 = 1'b0;
        prev4 = 1'b0;
        start16 = 0;
        start4 = 0;
        last_pop4 = 0;
        iv16 = 1'b0; a16 = '0; b16 = '0; or16 = 1'b1;
        iv4  = 1'b0; a4  = '0; b4  = '0; or4  = 1'b1;
        rst_n = 1'b1;
        #2 rst_n = 1'b0;
        #1;
        check("rst_in_ready16",  32'(ir16), 32'd1);
        check("rst_out_valid16", 32'(ov16), 32'd0);
        check("rst_diff16",      32'(d16),  32'd0);
        check("rst_borrow16",    32'(bo16), 32'd0);
        check("rst_zero16",      32'(z16),  32'd0);
        check("rst_in_ready4",   32'(ir4),  32'd1);
        check("rst_out_valid4",  32'(ov4),  32'd0);
        check("rst_diff4",       32'(d4),   32'd0);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;

        send16(16'h1234, 16'h0234);
        send16(16'h0000, 16'h0001);
        send16(16'hBEEF, 16'hBEEF);
        send16(16'h8000, 16'h7FFF);
        send16(16'hFFFF, 16'h0000);
        drain16();

        // Backpressure: result held in DONE while inputs wiggle
        or16 = 1'b0;
        send16(16'h0009, 16'h0003);
        wait_ov16();
        for (int k = 0; k < 10; k++) begin
            @(posedge clk);
            #1;
            a16  = 16'($urandom);
            b16  = 16'($urandom);
            iv16 = 1'($urandom_range(0, 1));
            @(negedge clk);
            check("bp_out_valid", 32'(ov16), 32'd1);
            check("bp_in_ready",  32'(ir16), 32'd0);
            check("bp_diff",      32'(d16),  32'h0006);
            check("bp_borrow",    32'(bo16), 32'd0);
        end
        @(posedge clk);
        #1;
        iv16 = 1'b0;
        or16 = 1'b1;
        @(posedge clk);
        #1;
        check("bp_release_ready", 32'(ir16), 32'd1);
        drain16();

        // Asynchronous reset while nibble 2 is being computed
        @(posedge clk);
        #1;
        iv16 = 1'b1;
        a16  = 16'h0000;
        b16  = 16'h0001;
        @(negedge clk);
        check("abort_accept_ready", 32'(ir16), 32'd1);
        @(posedge clk);
        #1;
        iv16 = 1'b0;
        @(posedge clk);
        @(posedge clk);
        #2 rst_n = 1'b0;
        #1;
        check("abort_out_valid", 32'(ov16), 32'd0);
        check("abort_diff",      32'(d16),  32'd0);
        check("abort_borrow",    32'(bo16), 32'd0);
        check("abort_in_ready",  32'(ir16), 32'd1);
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        send16(16'h0005, 16'h0003);
        drain16();

        // WIDTH=4: random pairs, in_valid held high, out_ready tied high
        b2b = 1'b1;
        iv4 = 1'b1;
        a4  = 4'($urandom);
        b4  = 4'($urandom);
        for (int i = 0; i < 1000; i++) begin
            logic done;
            done = 1'b0;
            for (int k = 0; k < 10 && !done; k++) begin
                @(negedge clk);
                if (ir4) begin
                    q4.push_back(model4(a4, b4, cyc));
                    done = 1'b1;
                end
            end
            if (!done) check("send4_timeout", 32'd0, 32'd1);
            @(posedge clk);
            #1;
            a4 = 4'($urandom);
            b4 = 4'($urandom);
        end
        iv4 = 1'b0;
        for (int k = 0; k < 20 && q4.size() != 0; k++) @(posedge clk);
        #1;
        check("drain4", 32'(q4.size()), 32'd0);
        b2b = 1'b0;

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
